parity_frame_accum: RTL and testbench

//   Streaming parity generator/checker. Reduces each WIDTH-bit input word to one parity bit.

---
 rtl/parity_frame_accum_if.sv | 32 +++
 rtl/parity_frame_accum.sv | 111 +++++++++++
 tb/tb_parity_frame_accum.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_accum_if.sv
// Handshake bundle for parity_frame_accum: word input stream and result token output.
// The slave modport is the block itself; the master modport is the surrounding logic
// that supplies words and consumes tokens.
interface parity_frame_accum_if #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             chk_en;
    logic             chk_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_err;
    logic [CW-1:0]    out_len;

    modport slave (
        input  in_valid, in_data, in_last, odd_mode, chk_en, chk_bit, out_ready,
        output in_ready, out_valid, out_parity, out_err, out_len
    );

    modport master (
        output in_valid, in_data, in_last, odd_mode, chk_en, chk_bit, out_ready,
        input  in_ready, out_valid, out_parity, out_err, out_len
    );
endinterface

// File: rtl/parity_frame_accum.sv
// Streaming parity accumulator. Each accepted word is folded to one parity bit and XORed
// into a running frame parity. A frame closes on in_last or on its FRAME_LEN-th word, after
// which one result token (parity, check error, word count) is held until downstream takes it.
module parity_frame_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_frame_accum_if.slave   bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_parity;
    logic          r_err;
    logic [CW-1:0] r_len;

    logic          w_accept;
    logic          w_emit;
    logic          w_close;
    logic          w_word_par;
    logic          w_mode;
    logic          w_parity;

    // Only the state and reset decide readiness; out_ready never reaches in_ready.
    assign bus.in_ready = rst_n & (r_state == ST_ACC);

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_emit     = bus.out_valid & bus.out_ready;
    assign w_close    = w_accept & (bus.in_last | (r_cnt == CW'(FRAME_LEN - 1)));
    assign w_word_par = ^bus.in_data;
    // The first word's odd_mode is not latched yet, so it is used directly.
    assign w_mode     = (r_cnt == '0) ? bus.odd_mode : r_mode;
    assign w_parity   = r_acc ^ w_word_par ^ w_mode;

    assign bus.out_parity = r_parity;
    assign bus.out_err    = r_err;
    assign bus.out_len    = r_len;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and token-valid decode.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (w_close) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (w_emit) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Frame datapath: accumulate in ACC, capture the token on close, clear it on emit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_parity <= 1'b0;
            r_err    <= 1'b0;
            r_len    <= '0;
        end else if (r_state == ST_ACC) begin
            if (w_close) begin
                // Accumulator is cleared here; it is idle until the token is emitted.
                r_acc    <= 1'b0;
                r_cnt    <= '0;
                r_parity <= w_parity;
                r_err    <= bus.chk_en & (w_parity != bus.chk_bit);
                r_len    <= r_cnt + CW'(1);
            end else if (w_accept) begin
                r_acc <= r_acc ^ w_word_par;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == '0) begin
                    r_mode <= bus.odd_mode;
                end
            end
        end else if (w_emit) begin
            r_parity <= 1'b0;
            r_err    <= 1'b0;
            r_len    <= '0;
        end
    end
endmodule

// File: tb/tb_parity_frame_accum.sv
// Bench for parity_frame_accum: directed scenarios plus randomized frames, all checked
// against a frame-level model (total set-bit count parity, word count, check rule).
module tb_parity_frame_accum;
    localparam int WIDTH = 8;
    localparam int FL    = 4;
    localparam int CW    = $clog2(FL + 1);

    logic clk;
    logic rst_n;

    int total;
    int bad;

    logic [WIDTH-1:0] fw [FL];

    parity_frame_accum_if #(.WIDTH(WIDTH), .FRAME_LEN(FL)) u_if ();
    parity_frame_accum_if #(.WIDTH(WIDTH), .FRAME_LEN(1))  u_if1 ();

    parity_frame_accum #(.WIDTH(WIDTH), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    parity_frame_accum #(.WIDTH(WIDTH), .FRAME_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.in_last   = 1'b0;
        u_if.odd_mode  = 1'b0;
        u_if.chk_en    = 1'b0;
        u_if.chk_bit   = 1'b0;
        u_if.out_ready = 1'b0;
        u_if1.in_valid  = 1'b0;
        u_if1.in_data   = '0;
        u_if1.in_last   = 1'b0;
        u_if1.odd_mode  = 1'b0;
        u_if1.chk_en    = 1'b0;
        u_if1.chk_bit   = 1'b0;
        u_if1.out_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks that the FRAME_LEN=4 block shows an empty, idle token interface.
    task automatic expect_idle(input string name, input logic want_ready);
        total++;
        if (u_if.out_valid !== 1'b0 || u_if.out_parity !== 1'b0 || u_if.out_err !== 1'b0 ||
            u_if.out_len !== '0) begin
            bad++;
            $display("FAIL %s outputs got v=%0b p=%0b e=%0b len=%0d want all 0", name,
                     u_if.out_valid, u_if.out_parity, u_if.out_err, u_if.out_len);
        end
        total++;
        if (u_if.in_ready !== want_ready) begin
            bad++;
            $display("FAIL %s in_ready got=%0b want=%0b", name, u_if.in_ready, want_ready);
        end
    endtask

    // Sends fw[0..n-1] as one frame, checks the token, holds it for `hold` cycles, emits it.
    task automatic run_frame(input int n, input logic mode, input logic en, input logic cb,
                             input int hold, input string name);
        int            ones;
        logic          exp_p;
        logic          exp_e;
        logic [CW-1:0] exp_len;
        ones = 0;
        for (int i = 0; i < n; i++) ones += $countones(fw[i]);
        exp_p   = ((ones % 2) == 1) ^ mode;
        exp_e   = en & (exp_p != cb);
        exp_len = CW'(n);

        for (int i = 0; i < n; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = fw[i];
            if (i == n - 1) begin
                u_if.in_last = (n < FL) ? 1'b1 : 1'($urandom_range(1, 0));
                u_if.chk_en  = en;
                u_if.chk_bit = cb;
            end else begin
                u_if.in_last = 1'b0;
                u_if.chk_en  = 1'($urandom_range(1, 0));
                u_if.chk_bit = 1'($urandom_range(1, 0));
            end
            u_if.odd_mode = (i == 0) ? mode : 1'($urandom_range(1, 0));
            total++;
            if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s word%0d in_ready=%0b out_valid=%0b want 1/0", name, i,
                         u_if.in_ready, u_if.out_valid);
            end
            step();
        end
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            total++;
            if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s hold%0d out_valid=%0b in_ready=%0b want 1/0", name, h,
                         u_if.out_valid, u_if.in_ready);
            end
            total++;
            if (u_if.out_parity !== exp_p) begin
                bad++;
                $display("FAIL %s hold%0d parity got=%0b want=%0b", name, h, u_if.out_parity, exp_p);
            end
            total++;
            if (u_if.out_err !== exp_e) begin
                bad++;
                $display("FAIL %s hold%0d err got=%0b want=%0b", name, h, u_if.out_err, exp_e);
            end
            total++;
            if (u_if.out_len !== exp_len) begin
                bad++;
                $display("FAIL %s hold%0d len got=%0d want=%0d", name, h, u_if.out_len, exp_len);
            end
            if (h < hold) begin
                // Words offered while the token is pending must be ignored.
                u_if.in_valid  = 1'b1;
                u_if.in_data   = WIDTH'($urandom);
                u_if.in_last   = 1'($urandom_range(1, 0));
                u_if.out_ready = 1'b0;
                step();
                u_if.in_valid = 1'b0;
            end
        end

        u_if.out_ready = 1'b1;
        step();
        u_if.out_ready = 1'b0;
        expect_idle({name, " after emit"}, 1'b1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        expect_idle("reset", 1'b0);
        total++;
        if (u_if1.out_valid !== 1'b0 || u_if1.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset dut1 out_valid=%0b in_ready=%0b want 0/0",
                     u_if1.out_valid, u_if1.in_ready);
        end
        rst_n = 1'b1;
        #1;
        expect_idle("reset release", 1'b1);
    endtask

    task automatic test_single_word();
        u_if1.in_valid = 1'b1;
        u_if1.in_data  = 8'b1011_1010;
        u_if1.odd_mode = 1'b0;
        total++;
        if (u_if1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single in_ready got=%0b want=1", u_if1.in_ready);
        end
        step();
        u_if1.in_valid = 1'b0;
        total++;
        if (u_if1.out_valid !== 1'b1 || u_if1.out_parity !== 1'b1 || u_if1.out_len !== 1'b1 ||
            u_if1.out_err !== 1'b0) begin
            bad++;
            $display("FAIL single token got v=%0b p=%0b len=%0d e=%0b want 1/1/1/0",
                     u_if1.out_valid, u_if1.out_parity, u_if1.out_len, u_if1.out_err);
        end
        u_if1.out_ready = 1'b1;
        step();
        u_if1.out_ready = 1'b0;
        total++;
        if (u_if1.out_valid !== 1'b0 || u_if1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single emit out_valid=%0b in_ready=%0b want 0/1",
                     u_if1.out_valid, u_if1.in_ready);
        end
        fw[0] = 8'b1011_1010;
        run_frame(1, 1'b0, 1'b0, 1'b0, 0, "single_fl4");
    endtask

    task automatic test_full_frame();
        fw[0] = 8'h01; fw[1] = 8'h03; fw[2] = 8'h07; fw[3] = 8'hFF;
        run_frame(4, 1'b0, 1'b0, 1'b0, 0, "full_even");
        run_frame(4, 1'b1, 1'b0, 1'b0, 0, "full_odd");
    endtask

    task automatic test_early_close();
        fw[0] = 8'h01; fw[1] = 8'h02;
        run_frame(2, 1'b0, 1'b0, 1'b0, 1, "early");
    endtask

    task automatic test_check();
        fw[0] = 8'h01; fw[1] = 8'h02;
        run_frame(2, 1'b0, 1'b1, 1'b1, 0, "chk_bit1");
        run_frame(2, 1'b0, 1'b1, 1'b0, 0, "chk_bit0");
        run_frame(2, 1'b0, 1'b0, 1'b1, 0, "chk_off");
    endtask

    task automatic test_backpressure();
        fw[0] = 8'hA5; fw[1] = 8'h3C; fw[2] = 8'h80;
        run_frame(3, 1'b1, 1'b1, 1'b1, 3, "backpressure");
    endtask

    task automatic test_reset_mid();
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h01;
        u_if.odd_mode = 1'b1;
        step();
        u_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_idle("mid reset comb", 1'b0);
        step();
        expect_idle("mid reset edge", 1'b0);
        rst_n = 1'b1;
        #1;
        fw[0] = 8'h03; fw[1] = 8'h00; fw[2] = 8'h00; fw[3] = 8'h00;
        run_frame(4, 1'b0, 1'b0, 1'b0, 0, "after_mid_reset");

        // Reset while a token is pending discards it.
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h01;
        u_if.in_last  = 1'b1;
        u_if.odd_mode = 1'b0;
        step();
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        total++;
        if (u_if.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL done before reset out_valid got=%0b want=1", u_if.out_valid);
        end
        rst_n = 1'b0;
        step();
        expect_idle("done reset", 1'b0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(FL, 1);
            for (int i = 0; i < FL; i++) fw[i] = WIDTH'($urandom);
            run_frame(n, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), $urandom_range(2, 0), "random");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_word();
        test_full_frame();
        test_early_close();
        test_check();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
